// File: rtl/setting_pkg.sv
// setting_pkg: shared simulation-state and key-code types for the setting controller.
package setting_pkg;
    typedef enum logic [1:0] {START, SIM, PAUSE, ENDING} sim_state_t;
    typedef enum logic [3:0] {
        KEY_STOP = 4'hA, KEY_RESUME, KEY_UP, KEY_DOWN, KEY_ESCAPE, KEY_ENTER
    } key_t;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/setting_controller_if.sv
// setting_controller_if: keypad strobe in, controller state and setting values out.
interface setting_controller_if #(parameter int NUM_SETTINGS = 4, parameter int VAL_W = 6);
    localparam int SEL_W = $clog2(NUM_SETTINGS);
    logic [3:0] keyCode;
    logic pressed;
    logic [1:0] simState;
    logic [SEL_W-1:0] setting;
    logic [VAL_W-1:0] entry;
    logic [2:0] digitCount;
    logic [NUM_SETTINGS*VAL_W-1:0] values;
    logic commit;
    modport master(output keyCode, pressed, input simState, setting, entry, digitCount, values, commit);
    modport slave(input keyCode, pressed, output simState, setting, entry, digitCount, values, commit);
endinterface

// File: rtl/decimal_entry.sv
// decimal_entry: bounded decimal accumulator; SETTING_BACKSPACE_EN makes backspace drop one digit,
// otherwise backspace clears the whole entry.
module decimal_entry #(
    parameter int VAL_W = 6,
    parameter int VAL_MAX = 63,
    parameter int MAX_DIGITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic digit_valid,
    input  logic [3:0] digit,
    input  logic clear,
    input  logic backspace,
    output logic [VAL_W-1:0] entry,
    output logic [2:0] digit_count
);
    localparam int CW = VAL_W + 4;
    logic [CW-1:0] cand;
    logic accept;
    // Candidate is kept 4 bits wider so an overflowing value is rejected, never wrapped.
    assign cand = CW'(entry) * CW'(10) + CW'(digit);
    assign accept = digit_valid && digit_count < 3'(MAX_DIGITS) && cand <= CW'(VAL_MAX);
`ifdef SETTING_BACKSPACE_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            entry <= '0;
            digit_count <= '0;
        end else if (accept) begin
            entry <= cand[VAL_W-1:0];
            digit_count <= digit_count + 3'd1;
        end else if (backspace && digit_count != 3'd0) begin
            entry <= entry / VAL_W'(10);
            digit_count <= digit_count - 3'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || clear || backspace) begin
            entry <= '0;
            digit_count <= '0;
        end else if (accept) begin
            entry <= cand[VAL_W-1:0];
            digit_count <= digit_count + 3'd1;
        end
    end
`endif
endmodule

// File: rtl/setting_controller.sv
// setting_controller: keypad-driven START/SIM/PAUSE/ENDING controller with bounded setting entry.
// Build option SETTING_BACKSPACE_EN turns ESCAPE into a one-digit backspace.
module setting_controller
    import setting_pkg::*;
#(
    parameter int NUM_SETTINGS = 4,
    parameter int VAL_W = 6,
    parameter int VAL_MAX = 63,
    parameter int MAX_DIGITS = 2,
    parameter int RESET_VAL = 0
) (
    input logic clk,
    input logic rst,
    setting_controller_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SETTINGS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SETTINGS - 1);
    sim_state_t state, state_nx;
    logic [SEL_W-1:0] sel;
    logic [VAL_W-1:0] vals [NUM_SETTINGS];
    logic [VAL_W-1:0] entry;
    logic [2:0] dcount;
    logic [NUM_SETTINGS*VAL_W-1:0] flat;
    logic commit_q, edit, resume, stop, up, down, esc, enter, is_digit;
    assign edit = bus.pressed && state == START;
    assign resume = bus.pressed && bus.keyCode == KEY_RESUME;
    assign stop = bus.pressed && bus.keyCode == KEY_STOP;
    assign up = edit && bus.keyCode == KEY_UP;
    assign down = edit && bus.keyCode == KEY_DOWN;
    assign esc = edit && bus.keyCode == KEY_ESCAPE;
    assign enter = edit && bus.keyCode == KEY_ENTER && dcount != 3'd0;
    assign is_digit = bus.keyCode <= DIGIT_MAX;
    always_comb begin
        state_nx = state;
        if (resume) state_nx = state == ENDING ? START : SIM;
        if (stop) state_nx = state == SIM ? PAUSE : state == PAUSE ? ENDING : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= START;
        else state <= state_nx;
    end
    // Leaving START via RESUME discards any partial entry in the same update.
    decimal_entry #(.VAL_W(VAL_W), .VAL_MAX(VAL_MAX), .MAX_DIGITS(MAX_DIGITS)) u_entry (
        .clk(clk),
        .rst(rst),
        .digit_valid(edit && is_digit),
        .digit(bus.keyCode),
        .clear(up || down || enter || (edit && resume)),
        .backspace(esc),
        .entry(entry),
        .digit_count(dcount)
    );
    always_ff @(posedge clk) begin
        if (rst) sel <= '0;
        else if (up) sel <= sel == LAST ? '0 : sel + SEL_W'(1);
        else if (down) sel <= sel == '0 ? LAST : sel - SEL_W'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETTINGS; i++) vals[i] <= VAL_W'(RESET_VAL);
            commit_q <= 1'b0;
        end else begin
            if (enter) vals[sel] <= entry;
            commit_q <= enter;
        end
    end
    always_comb begin
        flat = '0;
        for (int i = 0; i < NUM_SETTINGS; i++) flat[i*VAL_W +: VAL_W] = vals[i];
    end
    assign bus.simState = state;
    assign bus.setting = sel;
    assign bus.entry = entry;
    assign bus.digitCount = dcount;
    assign bus.values = flat;
    assign bus.commit = commit_q;
endmodule

// File: tb/tb_setting_controller.sv
// tb_setting_controller: directed key sequences checked every cycle against an integer model,
// plus hand-computed expectations at key points.
module tb_setting_controller;
    localparam int N = 4, W = 6, VMAX = 63, MD = 2, RV = 0;
    logic clk = 1'b0, rst = 1'b1;
    int total = 0, passed = 0;
    int m_state, m_sel, m_entry, m_cnt, m_val[N];
    bit m_commit, m_valid = 1'b0;
    always #5 clk = ~clk;
    setting_controller_if #(.NUM_SETTINGS(N), .VAL_W(W)) bus ();
    setting_controller #(.NUM_SETTINGS(N), .VAL_W(W), .VAL_MAX(VMAX), .MAX_DIGITS(MD), .RESET_VAL(RV))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask
    always @(posedge clk) begin : model
        int s, se, e, c, k, v[N];
        bit cm;
        s = m_state; se = m_sel; e = m_entry; c = m_cnt; v = m_val; cm = 0; k = bus.keyCode;
        if (rst) begin
            s = 0; se = 0; e = 0; c = 0;
            for (int i = 0; i < N; i++) v[i] = RV;
        end else if (bus.pressed) begin
            if (k == 10) s = s == 1 ? 2 : s == 2 ? 3 : s;
            else if (k == 11) begin
                if (s == 0) begin s = 1; e = 0; c = 0; end
                else if (s == 2) s = 1;
                else if (s == 3) s = 0;
            end else if (s == 0) begin
                if (k <= 9) begin
                    if (c < MD && e * 10 + k <= VMAX) begin e = e * 10 + k; c++; end
                end else if (k == 12) begin se = (se + 1) % N; e = 0; c = 0; end
                else if (k == 13) begin se = (se + N - 1) % N; e = 0; c = 0; end
                else if (k == 14) begin
`ifdef SETTING_BACKSPACE_EN
                    if (c > 0) begin e = e / 10; c--; end
`else
                    e = 0; c = 0;
`endif
                end else if (k == 15 && c > 0) begin v[se] = e; e = 0; c = 0; cm = 1; end
            end
        end
        m_state <= s; m_sel <= se; m_entry <= e; m_cnt <= c; m_val <= v; m_commit <= cm;
        if (rst) m_valid <= 1'b1;
    end
    always @(negedge clk) begin
        if (m_valid) begin
            chk("simState", bus.simState, m_state);
            chk("setting", bus.setting, m_sel);
            chk("entry", bus.entry, m_entry);
            chk("digitCount", bus.digitCount, m_cnt);
            chk("commit", bus.commit, m_commit);
            for (int i = 0; i < N; i++) chk("values", bus.values[i*W +: W], m_val[i]);
        end
    end
    task automatic key(input logic [3:0] k);
        bus.keyCode = k;
        bus.pressed = 1'b1;
        @(posedge clk);
        #1 bus.pressed = 1'b0;
        bus.keyCode = 4'h0;
    endtask
    initial begin
        bus.keyCode = 4'h0;
        bus.pressed = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset values", bus.values, 0);
        chk("reset simState", bus.simState, 0);
        chk("reset setting", bus.setting, 0);
        chk("reset commit", bus.commit, 0);
        key(4'h4); key(4'h2); key(4'hF);
        @(negedge clk);
        chk("value0 42", bus.values[5:0], 42);
        chk("commit pulse", bus.commit, 1);
        chk("entry after enter", bus.entry, 0);
        @(negedge clk);
        chk("commit drop", bus.commit, 0);
        key(4'h6); key(4'h4);
        @(negedge clk);
        chk("entry 64 rejected", bus.entry, 6);
        key(4'hE); key(4'h1); key(4'h2); key(4'h3);
        @(negedge clk);
        chk("entry 3rd digit rejected", bus.entry, 12);
        key(4'hD);
        @(negedge clk);
        chk("down wraps", bus.setting, 3);
        key(4'hC);
        @(negedge clk);
        chk("up wraps", bus.setting, 0);
        key(4'h5); key(4'hC);
        @(negedge clk);
        chk("up clears entry", bus.entry, 0);
        chk("up to 1", bus.setting, 1);
        key(4'hD); key(4'hD); key(4'h6); key(4'h3); key(4'hF);
        @(negedge clk);
        chk("value3 63", bus.values[23:18], 63);
        key(4'hC);
        key(4'hB);
        @(negedge clk);
        chk("resume->SIM", bus.simState, 1);
        key(4'h7); key(4'hF);
        @(negedge clk);
        chk("digit in SIM", bus.entry, 0);
        chk("values held in SIM", bus.values[5:0], 42);
        key(4'hA);
        @(negedge clk);
        chk("stop->PAUSE", bus.simState, 2);
        key(4'hA);
        @(negedge clk);
        chk("stop->ENDING", bus.simState, 3);
        key(4'hB);
        @(negedge clk);
        chk("resume->START", bus.simState, 0);
        key(4'h9); key(4'hB);
        @(negedge clk);
        chk("resume discards entry", bus.entry, 0);
        chk("resume discards count", bus.digitCount, 0);
        key(4'hA); key(4'hA); key(4'hB);
        key(4'h3); key(4'h7); key(4'hE);
        @(negedge clk);
`ifdef SETTING_BACKSPACE_EN
        chk("escape entry", bus.entry, 3);
        chk("escape count", bus.digitCount, 1);
`else
        chk("escape entry", bus.entry, 0);
        chk("escape count", bus.digitCount, 0);
`endif
        key(4'hE); key(4'h0); key(4'h5); key(4'hF);
        @(negedge clk);
        chk("leading zero", bus.values[5:0], 5);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.keyCode = 4'h8;
        bus.pressed = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.pressed = 1'b0;
        @(negedge clk);
        chk("rst beats key entry", bus.entry, 0);
        chk("rst clears values", bus.values, 0);
        repeat (2) @(negedge clk);
        #1 $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
